// File: rtl/booth_mult_param.sv
// Sequential radix-4 Booth multiplier: one Booth step per clock over WIDTH/2+1 steps,
// covering signed and unsigned operands through a WIDTH+2-bit internal extension.
`timescale 1ns/1ps
module booth_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             ready,
    output logic             busy,
    output logic             exception,
    output logic [1:0]       state_dbg
);
    localparam int E     = WIDTH + 2;
    localparam int PW    = E + 2;
    localparam int T     = PW + E + 1;
    localparam int STEPS = E / 2;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    // Handshake: a start is a 1 on ctrl_mult at a rising edge while not busy; the
    // operation completes with a one-cycle ready pulse, results then hold until the next one.
    state_t          state_q;
    logic [E-1:0]    mcand_q;
    logic [T-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q;
    logic            sgn_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic            ready_q, busy_q, exc_q;

    logic [E-1:0]    mcand_ext, mplier_ext;
    logic [PW-1:0]   p_cur, m_ext, addend, p_sum;
    logic [WIDTH-1:0] prod_lo, prod_hi;
    logic            prod_exc;

    always_comb begin
        mcand_ext  = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
        mplier_ext = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}     : {2'b00, multiplier};
        p_cur  = acc_q[T-1 -: PW];
        m_ext  = {{2{mcand_q[E-1]}}, mcand_q};
        // Triplet is {q[1], q[0], q[-1]}; the shift keeps q[-1] in acc_q[0].
        case (acc_q[2:0])
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        p_sum = p_cur + addend;
        acc_d = T'($signed({p_sum, acc_q[E:0]}) >>> 2);
        prod_lo  = acc_q[WIDTH:1];
        prod_hi  = acc_q[2*WIDTH:WIDTH+1];
        prod_exc = sgn_q ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}}) : (prod_hi != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    // One extra RUN cycle after the last step commits the product.
                    if (cnt_q == CW'(STEPS)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        lo_q    <= prod_lo;
                        hi_q    <= prod_hi;
                        exc_q   <= prod_exc;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (ctrl_mult) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        mcand_q <= mcand_ext;
                        sgn_q   <= is_signed;
                        acc_q   <= {{PW{1'b0}}, mplier_ext, 1'b0};
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign exception = exc_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: WIDTH=32 and WIDTH=8 instances, directed corner cases,
// protocol scenarios and randomized operands against an arithmetic product model.
`timescale 1ns/1ps
module tb_booth_mult_param;
  localparam int LAT32 = 18;
  localparam int LAT8  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic ctrl32, sgn32, ready32, busy32, exc32;
  logic [31:0] a32, b32, lo32, hi32;
  logic [1:0] st32;
  logic ctrl8, sgn8, ready8, busy8, exc8;
  logic [7:0] a8, b8, lo8, hi8;
  logic [1:0] st8;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  booth_mult_param #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .ctrl_mult(ctrl32), .is_signed(sgn32),
    .multiplicand(a32), .multiplier(b32), .result_lo(lo32), .result_hi(hi32),
    .ready(ready32), .busy(busy32), .exception(exc32), .state_dbg(st32)
  );

  booth_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .ctrl_mult(ctrl8), .is_signed(sgn8),
    .multiplicand(a8), .multiplier(b8), .result_lo(lo8), .result_hi(hi8),
    .ready(ready8), .busy(busy8), .exception(exc8), .state_dbg(st8)
  );

  function automatic logic [64:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, sp;
    logic [63:0] up;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      return {(sp < -64'sd2147483648) || (sp > 64'sd2147483647), 64'(sp)};
    end
    up = {32'd0, a} * {32'd0, b};
    return {up > 64'h0000_0000_FFFF_FFFF, up};
  endfunction

  function automatic logic [16:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int p;
    if (s) begin
      p = int'($signed(a)) * int'($signed(b));
      return {(p < -128) || (p > 127), 16'(p)};
    end
    p = int'(a) * int'(b);
    return {p > 255, 16'(p)};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    ctrl32 = 1'b1; a32 = a; b32 = b; sgn32 = s;
    @(posedge clk);
    #1;
    ctrl32 = 1'b0; a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
  endtask

  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
    logic [64:0] exp;
    exp_q.push_back(model32(a, b, s));
    start32(a, b, s);
    @(negedge clk);
    checks++;
    if (busy32 !== 1'b1 || ready32 !== 1'b0) begin
      errors++; $display("FAIL %s start: busy=%b ready=%b want busy=1 ready=0", name, busy32, ready32);
    end
    for (int k = 1; k <= LAT32; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy32 !== (k < LAT32) || ready32 !== (k == LAT32)) begin
        errors++;
        $display("FAIL %s edge %0d: busy=%b ready=%b want busy=%b ready=%b", name, k, busy32, ready32, k < LAT32, k == LAT32);
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if ({exc32, hi32, lo32} !== exp) begin
      errors++;
      $display("FAIL %s result: exc=%b hi=%h lo=%h want exc=%b hi=%h lo=%h", name, exc32, hi32, lo32, exp[64], exp[63:32], exp[31:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready32 !== 1'b0 || busy32 !== 1'b0 || {exc32, hi32, lo32} !== exp) begin
      errors++;
      $display("FAIL %s hold: ready=%b busy=%b hi=%h lo=%h want hold of hi=%h lo=%h", name, ready32, busy32, hi32, lo32, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string name);
    logic [16:0] exp;
    exp = model8(a, b, s);
    @(negedge clk);
    ctrl8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
    @(posedge clk);
    #1;
    ctrl8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    for (int k = 1; k <= LAT8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy8 !== (k < LAT8) || ready8 !== (k == LAT8)) begin
        errors++;
        $display("FAIL %s edge %0d: busy=%b ready=%b want busy=%b ready=%b", name, k, busy8, ready8, k < LAT8, k == LAT8);
      end
    end
    checks++;
    if ({exc8, hi8, lo8} !== exp) begin
      errors++;
      $display("FAIL %s result: exc=%b hi=%h lo=%h want exc=%b hi=%h lo=%h", name, exc8, hi8, lo8, exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ctrl32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    ctrl8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lo32, hi32, ready32, busy32, exc32} !== '0 || {lo8, hi8, ready8, busy8, exc8} !== '0) begin
      errors++;
      $display("FAIL reset_state: lo=%h hi=%h r=%b b=%b e=%b want all 0", lo32, hi32, ready32, busy32, exc32);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed32();
    run_op32(32'd7, 32'hFFFF_FFFD, 1'b1, "s7x-3");
    run_op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "smin_x_m1");
    run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax_sq");
    run_op32(32'h0000_FFFF, 32'h0001_0001, 1'b0, "u_ffff_x_10001");
    run_op32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "smax_sq");
    run_op32(32'h8000_0000, 32'h0000_0001, 1'b1, "smin_x_1");
  endtask

  task automatic test_width8();
    run_op8(8'h80, 8'h80, 1'b1, "w8_min_sq");
    run_op8(8'h0F, 8'h11, 1'b0, "w8_u_fit");
    for (int i = 0; i < 16; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), "w8_rand");
  endtask

  task automatic test_ignore_restart();
    int ready_cnt;
    ready_cnt = 0;
    @(negedge clk);
    ctrl32 = 1'b1; a32 = 32'd5; b32 = 32'd6; sgn32 = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) begin
        ctrl32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
      end else begin
        ctrl32 = 1'b0;
      end
      if (ready32) ready_cnt++;
      if (k == LAT32) begin
        checks++;
        if (ready32 !== 1'b1 || lo32 !== 32'd30 || hi32 !== 32'd0) begin
          errors++;
          $display("FAIL ignore_restart result: ready=%b lo=%0d hi=%0d want ready=1 lo=30 hi=0", ready32, lo32, hi32);
        end
      end
    end
    checks++;
    if (ready_cnt != 1) begin
      errors++; $display("FAIL ignore_restart pulses: got %0d want 1", ready_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int ready_cnt;
    ready_cnt = 0;
    start32(32'd1234, 32'd5678, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({lo32, hi32, ready32, busy32, exc32} !== '0 || {lo8, hi8, ready8, busy8, exc8} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: lo=%h hi=%h r=%b b=%b e=%b want all 0", lo32, hi32, ready32, busy32, exc32);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (ready32 || busy32) ready_cnt++;
    end
    checks++;
    if (ready_cnt != 0) begin
      errors++; $display("FAIL reset_no_ready: got %0d active cycles want 0", ready_cnt);
    end
    run_op32(32'hFFFF_FFF6, 32'd12, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp_a, exp_b;
    int ready_cnt;
    ready_cnt = 0;
    exp_a = model32(32'd3, 32'd6, 1'b0);
    exp_b = model32(32'hFFFF_FFFE, 32'd9, 1'b1);
    start32(32'd3, 32'd6, 1'b0);
    for (int k = 1; k <= 2 * LAT32 + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      ctrl32 = 1'b0;
      if (ready32) ready_cnt++;
      if (k == LAT32) begin
        checks++;
        if (ready32 !== 1'b1 || {exc32, hi32, lo32} !== exp_a) begin
          errors++; $display("FAIL b2b first: ready=%b hi=%h lo=%h want 1 %h %h", ready32, hi32, lo32, exp_a[63:32], exp_a[31:0]);
        end
        ctrl32 = 1'b1; a32 = 32'hFFFF_FFFE; b32 = 32'd9; sgn32 = 1'b1;
      end
      if (k == 2 * LAT32 + 1) begin
        checks++;
        if (ready32 !== 1'b1 || {exc32, hi32, lo32} !== exp_b) begin
          errors++; $display("FAIL b2b second: ready=%b hi=%h lo=%h want 1 %h %h", ready32, hi32, lo32, exp_b[63:32], exp_b[31:0]);
        end
      end
    end
    checks++;
    if (ready_cnt != 2) begin
      errors++; $display("FAIL b2b pulses: got %0d want 2", ready_cnt);
    end
  endtask

  task automatic test_random32();
    for (int i = 0; i < 30; i++)
      run_op32(pick32(), pick32(), 1'($urandom), "rand32");
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_width8();
    test_ignore_restart();
    test_reset_mid_run();
    test_back_to_back();
    test_random32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
